// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter: round-robin arbiter that shares the single W5300
// parallel read/write engine between NREQ requesters. One single-word
// transaction is latched, held on c_addr/c_idata for a full engine bus
// cycle, and completed with a done pulse (or err pulse on timeout).
module w5300_bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*10-1:0]   req_addr,
    input  logic [NREQ*16-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [15:0]          rdata,
    output logic [10:0]          c_addr,
    output logic [15:0]          c_idata,
    input  logic [15:0]          c_odata,
    input  logic                 rw_ready
);
    localparam int unsigned   PW       = $clog2(NREQ);
    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [10:0]     c_addr_q, c_addr_d;
    logic [15:0]     c_idata_q, c_idata_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] win_oh;
    logic            sel_wr;
    logic [9:0]      sel_addr;
    logic [15:0]     sel_wdata;
    logic [CW-1:0]   cnt_inc;

    // Round-robin search: first requesting index after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's transaction fields and form its one-hot grant.
    always_comb begin
        win_oh    = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_oh[i] = 1'b1;
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*10 +: 10];
                sel_wdata = req_wdata[i*16 +: 16];
            end
        end
    end

    // Next-state and output logic of the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        c_addr_d  = c_addr_q;
        c_idata_d = c_idata_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d   = win_idx;
                    gnt_d     = win_oh;
                    c_addr_d  = {~sel_wr, sel_addr};
                    c_idata_d = sel_wdata;
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Engine acceptance is checked before the timeout so a drop on the last allowed cycle still counts.
                if (!rw_ready) begin
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= CNT_LAST) begin
                        err_d   = gnt_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (rw_ready) begin
                    if (c_addr_q[10]) begin
                        rdata_d = c_odata;
                    end
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= CNT_LAST) begin
                        err_d   = gnt_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            c_addr_q  <= 11'h400;
            c_idata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            c_addr_q  <= c_addr_d;
            c_idata_q <= c_idata_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign c_addr  = c_addr_q;
    assign c_idata = c_idata_q;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Bench for w5300_bus_arbiter: randomized requesters and engine, with a
// transaction-level reference model feeding a scoreboard that a separate
// monitor drains on every done/err pulse.
module tb_w5300_bus_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_wr;
    logic [NREQ*10-1:0] req_addr;
    logic [NREQ*16-1:0] req_wdata;
    logic [NREQ-1:0]   gnt, done, err;
    logic [15:0]       rdata;
    logic [10:0]       c_addr;
    logic [15:0]       c_idata;
    logic [15:0]       c_odata = '0;
    logic              rw_ready = 1'b1;

    logic              rq_wr    [NREQ];
    logic [9:0]        rq_addr  [NREQ];
    logic [15:0]       rq_wdata [NREQ];
    int                rq_c     [NREQ];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_wr[gi]              = rq_wr[gi];
        assign req_addr[10*gi +: 10]   = rq_addr[gi];
        assign req_wdata[16*gi +: 16]  = rq_wdata[gi];
    end

    w5300_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .c_addr(c_addr), .c_idata(c_idata),
        .c_odata(c_odata), .rw_ready(rw_ready)
    );

    typedef struct {
        int          owner;
        logic [10:0] caddr;
        logic [15:0] cidata;
        bit          is_err;
        logic [15:0] rdata;
        int          g;
        int          c;
    } exp_t;

    typedef struct {
        int          d;      // cycles before the engine drops rw_ready
        int          l;      // cycles rw_ready stays low
        logic [15:0] data;
    } plan_t;

    exp_t  sb[$];
    plan_t plan_q[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_next = 0;
    int          m_ptr = NREQ - 1;
    logic [15:0] m_rdata = '0;
    int          eng_lo = 0;
    int          eng_hi = -1;
    logic [15:0] eng_data = '0;
    int          keep_pct = 0;
    int          auto_pct = 0;

    function automatic logic [1:0] ix(input int i);
        return 2'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_fields(input int i);
        rq_wr[ix(i)]    = 1'($urandom);
        rq_addr[ix(i)]  = 10'($urandom);
        rq_wdata[ix(i)] = 16'($urandom);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [9:0] a, input logic [15:0] d);
        rq_wr[ix(i)]    = wr;
        rq_addr[ix(i)]  = a;
        rq_wdata[ix(i)] = d;
        req[ix(i)]      = 1'b1;
    endtask

    // Reference model: on each edge it arbitrates round-robin among the
    // requests visible at that edge, picks an engine plan, and derives the
    // completion edge from the rules: done one edge after rw_ready returns
    // high, err TO edges after grant if the engine never accepts, or TO edges
    // into the bus cycle if it never finishes; next arbitration two edges later.
    initial begin : model
        int          w;
        logic [1:0]  wi;
        plan_t       p;
        exp_t        e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_next  = 0;
                m_ptr   = NREQ - 1;
                m_rdata = '0;
                eng_lo  = 0;
                eng_hi  = -1;
            end else if (cyc >= m_next && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    wi = ix((m_ptr + k) % NREQ);
                    if (w < 0 && req[wi]) w = (m_ptr + k) % NREQ;
                end
                wi    = ix(w);
                m_ptr = w;
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                end else begin
                    p.d    = $urandom_range(0, 3);
                    p.l    = $urandom_range(1, 8);
                    p.data = 16'($urandom);
                    if ($urandom_range(0, 19) == 0) p.d = TO + 4;
                    else if ($urandom_range(0, 19) == 0) p.l = TO + 3;
                end
                e.owner  = w;
                e.caddr  = {~rq_wr[wi], rq_addr[wi]};
                e.cidata = rq_wdata[wi];
                e.g      = cyc;
                if (p.d >= TO) begin
                    e.c = cyc + TO;             e.is_err = 1'b1;
                end else if (p.l > TO) begin
                    e.c = cyc + p.d + 1 + TO;   e.is_err = 1'b1;
                end else begin
                    e.c = cyc + p.d + 1 + p.l;  e.is_err = 1'b0;
                end
                if (!e.is_err && !rq_wr[wi]) m_rdata = p.data;
                e.rdata = m_rdata;
                sb.push_back(e);
                eng_lo   = cyc + p.d + 1;
                eng_hi   = (cyc + p.d + p.l < e.c) ? cyc + p.d + p.l : e.c;
                eng_data = p.data;
                rq_c[wi] = e.c;
                m_next   = e.c + 2;
            end
        end
    end

    // Engine and requester drivers: update inputs on the falling edge.
    initial begin : driver
        forever begin
            @(negedge clk);
            rw_ready = !((cyc + 1) >= eng_lo && (cyc + 1) <= eng_hi);
            c_odata  = eng_data;
            for (int i = 0; i < NREQ; i++) begin
                if (req[ix(i)] && rq_c[ix(i)] == cyc) begin
                    rq_c[ix(i)] = -1;
                    if ($urandom_range(0, 99) < keep_pct) new_fields(i);
                    else req[ix(i)] = 1'b0;
                end else if (!req[ix(i)] && $urandom_range(0, 99) < auto_pct) begin
                    new_fields(i);
                    req[ix(i)] = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    int          g_seen = 0;
    logic [NREQ-1:0] gnt_prev = '0;
    logic [15:0] mon_rdata = '0;
    exp_t        me;
    logic [NREQ-1:0] oh;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gnt_prev  = '0;
                mon_rdata = '0;
            end else begin
                if (gnt != '0 && gnt_prev == '0) begin
                    g_seen = cyc;
                    check("rdata_hold", rdata, mon_rdata);
                end
                if ((done | err) != '0) begin
                    if (sb.size() == 0) begin
                        check("spurious_pulse", {done, err}, 0);
                    end else begin
                        me = sb.pop_front();
                        oh = NREQ'(1) << me.owner;
                        check("pulse", {done, err}, me.is_err ? {4'b0, oh} : {oh, 4'b0});
                        check("timing", {32'(g_seen), 32'(cyc)}, {32'(me.g), 32'(me.c)});
                        check("bus", {c_addr, c_idata}, {me.caddr, me.cidata});
                        check("gnt", gnt, oh);
                        check("rdata", rdata, me.rdata);
                        mon_rdata = me.rdata;
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].c) begin
                    me = sb.pop_front();
                    oh = NREQ'(1) << me.owner;
                    check("missing_pulse", {done, err}, me.is_err ? {4'b0, oh} : {oh, 4'b0});
                end
                gnt_prev = gnt;
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        keep_pct = 0;
        auto_pct = 0;
        while (!(req == '0 && sb.size() == 0 && cyc >= m_next) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", {32'(sb.size()), 28'(0), req}, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        for (int i = 0; i < NREQ; i++) begin
            rq_wr[ix(i)] = 1'b0; rq_addr[ix(i)] = '0; rq_wdata[ix(i)] = '0; rq_c[ix(i)] = -1;
        end
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_caddr", c_addr, 11'h400);
        check("rst_cidata", c_idata, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single write from requester 0
        @(negedge clk); #1;
        plan_q.push_back('{1, 6, 16'h0});
        set_req(0, 1'b1, 10'h008, 16'hBEEF);
        drain(100);

        // Single read from requester 2
        @(negedge clk); #1;
        plan_q.push_back('{0, 5, 16'h1234});
        set_req(2, 1'b0, 10'h3FE, 16'h0);
        drain(100);
        check("read_rdata_held", rdata, 16'h1234);
        check("idle_caddr_kept", c_addr, 11'h7FE);

        // All four held continuously: round-robin rotation
        @(negedge clk); #1;
        keep_pct = 100;
        for (int i = 0; i < NREQ; i++) begin
            new_fields(i);
            req[ix(i)] = 1'b1;
        end
        repeat (80) @(negedge clk);
        drain(300);

        // Late arrival of 0 and 3 while 1 is mid bus cycle
        @(negedge clk); #1;
        plan_q.push_back('{0, 8, 16'h5A5A});
        set_req(1, 1'b0, 10'h123, 16'h0);
        repeat (4) @(negedge clk); #1;
        set_req(0, 1'b1, 10'h001, 16'h1111);
        set_req(3, 1'b0, 10'h333, 16'h3333);
        drain(200);

        // Timeouts: engine never accepts, then never finishes, then normal
        @(negedge clk); #1;
        plan_q.push_back('{TO + 10, 1, 16'hDEAD});
        plan_q.push_back('{0, TO + 5, 16'hBEAD});
        plan_q.push_back('{1, 3, 16'hA5A5});
        set_req(1, 1'b0, 10'h010, 16'h0);
        set_req(2, 1'b0, 10'h020, 16'h0);
        set_req(3, 1'b0, 10'h030, 16'h0);
        drain(300);

        // Randomized traffic
        @(negedge clk); #1;
        keep_pct = 30;
        auto_pct = 10;
        repeat (2000) @(negedge clk);
        drain(400);

        // Reset in the middle of a bus cycle
        @(negedge clk); #1;
        plan_q.push_back('{0, 12, 16'h7777});
        set_req(2, 1'b0, 10'h2AA, 16'h0);
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_done_err", {done, err}, 0);
        check("midrst_caddr", c_addr, 11'h400);
        check("midrst_rdata", rdata, 0);
        sb.delete();
        plan_q.delete();
        req = '0;
        for (int i = 0; i < NREQ; i++) rq_c[ix(i)] = -1;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        set_req(1, 1'b1, 10'h044, 16'h4444);
        set_req(0, 1'b1, 10'h055, 16'h5555);
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/w5300_bus_arbiter.md
# w5300_bus_arbiter

Round-robin arbiter and transaction sequencer that shares the single W5300 parallel read/write engine (`_w5300_parallel_if_rw`) between `NREQ` independent requesters, such as the init sequencer, socket TX path and socket RX path. It does three things:
- Latches one requester's single-word read or write.
- Presents it on the engine's `c_addr`/`c_idata` and holds it there until the engine has completed one full bus cycle.
- Returns read data and a per-requester done or error pulse.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: maximum cycles spent in any engine-wait state before the transaction is aborted. Range 1..65535.

Ports:
- `clk`  in  1: single system clock; everything is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: level request per requester. It must be held until that requester's `done` or `err` pulse.
- `req_wr`  in  NREQ: 1 = write, 0 = read. Sampled at grant.
- `req_addr`  in  NREQ*10: packed word addresses; requester i uses `[10*i+9:10*i]`. Sampled at grant.
- `req_wdata`  in  NREQ*16: packed write data; requester i uses `[16*i+15:16*i]`. Sampled at grant.
- `gnt`  out  NREQ: one-hot; high from grant until the cycle after `done`/`err`.
- `done`  out  NREQ: one-cycle pulse to the owner on successful completion.
- `err`  out  NREQ: one-cycle pulse to the owner on timeout. No `done` is pulsed.
- `rdata`  out  16: read result. Valid in the `done` cycle and held until the next read completes.
- `c_addr`  out  11: to the engine. Bit 10 = 1 for read, 0 for write; bits [9:0] = address.
- `c_idata`  out  16: write data to the engine.
- `c_odata`  in  16: read data from the engine.
- `rw_ready`  in  1: engine status. Low while a bus cycle is in progress.

## Operation
State machine:
- **IDLE**
  - If `req` is nonzero, choose the winner by round-robin, searching from index `ptr+1` upward modulo `NREQ`.
  - Latch `req_wr`, `req_addr` and `req_wdata` of the winner into `c_addr`/`c_idata`.
  - Set `gnt` one-hot, clear the timeout counter, and go to **ISSUE**.
- **ISSUE**: wait for `rw_ready == 0`, which means the engine has taken the address. Then clear the counter and go to **BUSY**.
- **BUSY**: wait for `rw_ready == 1`. Then capture `c_odata` into `rdata` if this is a read, pulse `done[owner]`, and go to **DONE**.
- **DONE**: drop `gnt`, set `ptr` to the owner index, and go to **IDLE**. This inserts one bubble cycle between transactions.
- **Timeout**
  - In ISSUE or BUSY, the counter increments every cycle.
  - When it reaches `TIMEOUT`, pulse `err[owner]` instead of `done`, leave `rdata` unchanged, and go to **DONE**.
  - Counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.

Rules:
- Round-robin fairness: after requester k is served, k has the lowest priority in the next arbitration.
- `ptr` resets to `NREQ-1`, so requester 0 wins first.
- `c_addr` and `c_idata` are held constant from the grant until the cycle after `done`/`err`. In IDLE they retain their last value.
- `req` deasserting mid-transaction is illegal and ignored. The transaction completes and `done` is still pulsed.
- A `req` bit rising during another owner's transaction is considered only at the next IDLE.
- If the same requester keeps `req` high through its `done` cycle, it is treated as a new request and competes normally.
- Reset mid-transaction: all state returns to reset values immediately. The engine's own reset is responsible for the physical bus.

Reset values:
- `gnt`, `done`, `err` = 0.
- `rdata` = 0.
- `c_addr` = 11'h400, a read of address 0, which is harmless.
- `c_idata` = 0.
- `ptr` = `NREQ-1`.
- State = IDLE; counter = 0.

## Timing
- From a `req` sampled high in IDLE, `gnt` and `c_addr` are valid at the next edge (1 cycle).
- The engine cycle is about 8 clocks (ADDR_SETUP through CPLT plus 4 keep ticks). Total latency from `req` to `done` is about 10 cycles.
- `done`/`err` is registered and asserts the cycle after `rw_ready` rises or the timeout is hit. It is high for exactly 1 cycle.
- `gnt` deasserts 1 cycle after `done`. The next grant comes no earlier than 2 cycles after `done`.
- `rw_ready` already low on entry to ISSUE is accepted in the first ISSUE cycle.

## Test plan
1. **Single write.** After reset, `req=4'b0001`, `req_wr[0]=1`, addr `10'h008`, wdata `16'hBEEF`; engine model drops `rw_ready` for 6 cycles.
   -> `c_addr=11'h008`, `c_idata=16'hBEEF`; `done=4'b0001` for one cycle; `err` stays 0.
2. **Single read.** Requester 2 reads `10'h3FE`; engine returns `c_odata=16'h1234`.
   -> `c_addr=11'h7FE`; `done=4'b0100`; `rdata=16'h1234` in the `done` cycle and held afterwards.
3. **Round-robin.** All four `req` held high continuously from reset.
   -> Grant order is 0,1,2,3,0,1…; never two consecutive grants to the same index; one IDLE bubble between transactions.
4. **Late arrival.** `req[3]` rises while requester 1 is in BUSY.
   -> Requester 1 completes; requester 3 is served next ahead of 0 (ptr=1).
5. **Timeout.** `TIMEOUT=16`; engine holds `rw_ready=1` forever.
   -> `err[owner]` pulses 16 cycles after entering ISSUE; no `done`; `rdata` unchanged; the next requester is served.
6. **Mid-transaction reset.** Assert `rst_n=0` during BUSY.
   -> `gnt`, `done`, `err` = 0 and `c_addr=11'h400` immediately; after release, requester 0 is granted first.
